// File: rtl/ram_pkg.sv
// Shared defaults and state encoding for the RAM write packer.
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2,
    ST_DONE = 2'd3
  } pack_state_e;

endpackage : ram_pkg

// File: rtl/ram_write_packer.sv
// Packs a valid/ready byte stream into paired port-A/port-B RAM writes at addr, addr+1;
// a trailing odd byte goes through port A alone, and done pulses after the final write.
module ram_write_packer
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  overflow,
  output logic                  we_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);

  // Block size at which byte_count saturates: the full RAM depth.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  pack_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic                  we_a_q, we_a_d;
  logic                  we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  accept;

  assign s_ready = (state_q == ST_EVEN) || (state_q == ST_ODD);
  assign busy    = (state_q != ST_IDLE);
  assign accept  = s_valid && s_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    hold_d     = hold_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    we_a_d     = 1'b0;
    we_b_d     = 1'b0;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;

    if (accept) begin
      if (count_q == DEPTH) overflow_d = 1'b1;
      else                  count_d    = count_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          wr_ptr_d   = base_addr;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ST_EVEN;
        end
      end
      ST_EVEN: begin
        if (accept) begin
          if (s_last) begin
            we_a_d   = 1'b1;
            addr_a_d = wr_ptr_q;
            data_a_d = s_data;
            state_d  = ST_DONE;
          end else begin
            hold_d  = s_data;
            state_d = ST_ODD;
          end
        end
      end
      ST_ODD: begin
        if (accept) begin
          we_a_d   = 1'b1;
          we_b_d   = 1'b1;
          addr_a_d = wr_ptr_q;
          // Address arithmetic wraps modulo the RAM depth by truncation.
          addr_b_d = wr_ptr_q + ADDR_WIDTH'(1);
          data_a_d = hold_q;
          data_b_d = s_data;
          wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(2);
          state_d  = s_last ? ST_DONE : ST_EVEN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so every output reads 0 straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      hold_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      we_a_q     <= we_a_d;
      we_b_q     <= we_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
    end
  end

  assign done       = done_q;
  assign byte_count = count_q;
  assign overflow   = overflow_q;
  assign we_a       = we_a_q;
  assign we_b       = we_b_q;
  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign data_a     = data_a_q;
  assign data_b     = data_b_q;

endmodule : ram_write_packer

// File: tb/tb_ram_write_packer.sv
// Directed bench for ram_write_packer: a RAM model on the write ports plus per-scenario tasks.
module tb_ram_write_packer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] base_addr;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       busy;
  logic       done;
  logic [10:0] byte_count;
  logic       overflow;
  logic       we_a, we_b;
  logic [9:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;

  ram_write_packer #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .busy(busy), .done(done), .byte_count(byte_count), .overflow(overflow),
    .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  logic [7:0] blk [0:1099];
  int cyc = 0;
  int dual_cnt, a_only_cnt, b_cnt, done_cnt, last_we_cyc, done_cyc;
  logic [9:0] last_addr_a, last_addr_b;

  // RAM model and write-pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (we_a) begin mem[addr_a] = data_a; last_addr_a = addr_a; end
    if (we_b) begin mem[addr_b] = data_b; last_addr_b = addr_b; b_cnt++; end
    if (we_a && we_b) dual_cnt++;
    if (we_a && !we_b) a_only_cnt++;
    if (we_a || we_b) last_we_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_model();
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    dual_cnt = 0; a_only_cnt = 0; b_cnt = 0; done_cnt = 0;
    last_we_cyc = 0; done_cyc = 0; last_addr_a = '0; last_addr_b = '0;
  endtask

  task automatic start_block(input logic [9:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n_send, input int total, input bit gaps, input int spur_at);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n_send && guard < 5000) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = blk[i];
      s_last  = (i == total - 1);
      start   = (i == spur_at);
      if (i == spur_at) base_addr = 10'h300;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    checks++;
    if (i !== n_send) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d bytes, required %0d", i, n_send);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done never pulsed within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_image(input string name, input logic [9:0] base, input int n);
    int bad = 0;
    for (int k = 0; k < n; k++)
      if (mem[10'(int'(base) + k)] !== blk[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d of %0d RAM bytes differ, required 0", name, bad, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, busy, done, byte_count, overflow, we_a, we_b, addr_a, addr_b, data_a, data_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b cnt=%0d we=%b%b, required all 0",
               s_ready, busy, done, byte_count, we_a, we_b);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ascii_block();
    string s = "This RAM module can read and write.";
    clear_model();
    for (int k = 0; k < 35; k++) blk[k] = s[k];
    start_block(10'h000);
    stream(35, 35, 1'b0, -1);
    wait_done();
    checks++;
    if (dual_cnt !== 17) begin errors++; $display("FAIL ascii_dual: %0d dual writes, required 17", dual_cnt); end
    checks++;
    if (a_only_cnt !== 1) begin errors++; $display("FAIL ascii_single: %0d A-only writes, required 1", a_only_cnt); end
    checks++;
    if (mem[10'h022] !== 8'h2E || last_addr_a !== 10'h022) begin
      errors++;
      $display("FAIL ascii_tail: mem[0x22]=%h last addr_a=%h, required 2e at 022", mem[10'h022], last_addr_a);
    end
    checks++;
    if (done_cyc !== last_we_cyc + 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL ascii_done_timing: done cyc %0d (count %0d), last we cyc %0d, required we+1 once",
               done_cyc, done_cnt, last_we_cyc);
    end
    checks++;
    if (byte_count !== 11'd35) begin errors++; $display("FAIL ascii_count: %0d, required 35", byte_count); end
    check_image("ascii_image", 10'h000, 35);
  endtask

  task automatic test_wrap_pair();
    clear_model();
    blk[0] = 8'hAB; blk[1] = 8'hCD;
    start_block(10'h3FF);
    stream(2, 2, 1'b0, -1);
    wait_done();
    checks++;
    if (mem[10'h3FF] !== 8'hAB || mem[10'h000] !== 8'hCD) begin
      errors++;
      $display("FAIL wrap_data: mem[3ff]=%h mem[000]=%h, required ab cd", mem[10'h3FF], mem[10'h000]);
    end
    checks++;
    if (last_addr_a !== 10'h3FF || last_addr_b !== 10'h000 || dual_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_addr: A=%h B=%h dual=%0d, required 3ff 000 1", last_addr_a, last_addr_b, dual_cnt);
    end
    checks++;
    if (byte_count !== 11'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: cnt=%0d ovf=%b, required 2 0", byte_count, overflow);
    end
  endtask

  task automatic test_single_byte();
    clear_model();
    blk[0] = 8'h5A;
    start_block(10'h010);
    stream(1, 1, 1'b0, -1);
    wait_done();
    checks++;
    if (b_cnt !== 0 || a_only_cnt !== 1) begin
      errors++;
      $display("FAIL single_we: we_b pulses=%0d A-only=%0d, required 0 1", b_cnt, a_only_cnt);
    end
    checks++;
    if (mem[10'h010] !== 8'h5A || last_addr_a !== 10'h010) begin
      errors++;
      $display("FAIL single_data: mem[010]=%h addr_a=%h, required 5a 010", mem[10'h010], last_addr_a);
    end
    checks++;
    if (byte_count !== 11'd1) begin errors++; $display("FAIL single_count: %0d, required 1", byte_count); end
  endtask

  task automatic test_valid_gaps();
    clear_model();
    for (int k = 0; k < 16; k++) blk[k] = 8'(8'h11 * (k + 1) + k);
    start_block(10'h100);
    stream(16, 16, 1'b1, -1);
    wait_done();
    check_image("gaps_image", 10'h100, 16);
    checks++;
    if (dual_cnt !== 8 || a_only_cnt !== 0) begin
      errors++;
      $display("FAIL gaps_pulses: dual=%0d A-only=%0d, required 8 0", dual_cnt, a_only_cnt);
    end
    checks++;
    if (byte_count !== 11'd16) begin errors++; $display("FAIL gaps_count: %0d, required 16", byte_count); end
  endtask

  task automatic test_reset_mid_block();
    clear_model();
    for (int k = 0; k < 10; k++) blk[k] = 8'(8'hA0 + k);
    start_block(10'h040);
    stream(5, 10, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, busy, done, byte_count, overflow, we_a, we_b, addr_a, addr_b, data_a, data_b} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: ready=%b busy=%b cnt=%0d we=%b%b, required all 0",
               s_ready, busy, byte_count, we_a, we_b);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL midreset_done: %0d done pulses, required 0", done_cnt); end
    clear_model();
    for (int k = 0; k < 4; k++) blk[k] = 8'(8'hC0 + k);
    start_block(10'h200);
    stream(4, 4, 1'b0, -1);
    wait_done();
    check_image("midreset_restart", 10'h200, 4);
  endtask

  task automatic test_start_busy_overflow();
    clear_model();
    for (int k = 0; k < 6; k++) blk[k] = 8'(8'h31 + k);
    start_block(10'h080);
    stream(6, 6, 1'b0, 2);
    wait_done();
    check_image("busy_start_image", 10'h080, 6);
    checks++;
    if (mem[10'h300] !== 8'h00 || byte_count !== 11'd6) begin
      errors++;
      $display("FAIL busy_start_ignored: mem[300]=%h cnt=%0d, required 00 6", mem[10'h300], byte_count);
    end
    clear_model();
    for (int k = 0; k < 1025; k++) blk[k] = 8'((k * 7 + 3) & 255);
    start_block(10'h000);
    stream(1025, 1025, 1'b0, -1);
    wait_done();
    checks++;
    if (overflow !== 1'b1 || byte_count !== 11'd1024) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d, required 1 1024", overflow, byte_count);
    end
    checks++;
    if (mem[10'h000] !== 8'h03 || mem[10'h001] !== 8'h0A || mem[10'h3FF] !== blk[1023]) begin
      errors++;
      $display("FAIL overflow_wrap: mem[0]=%h mem[1]=%h mem[3ff]=%h, required 03 0a %h",
               mem[10'h000], mem[10'h001], mem[10'h3FF], blk[1023]);
    end
  endtask

  initial begin
    test_reset();
    test_ascii_block();
    test_wrap_pair();
    test_single_byte();
    test_valid_gaps();
    test_reset_mid_block();
    test_start_busy_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_write_packer
